// File: rtl/decrypt_pkg.sv
// Shared constants, FSM state encoding and LFSR step for the message-decryption engine.
package decrypt_pkg;

    localparam int MSG_BASE = 64;
    localparam int OUT_LEN  = 54;
    localparam int PRE_MIN  = 10;
    localparam int NUM_TAPS = 9;

    // Candidate feedback patterns, tried in this order during the tap search.
    localparam logic [6:0] TAP_TABLE [0:NUM_TAPS-1] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SEARCH,
        ST_SCAN,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read port, synchronous write port, no reset.
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    always_ff @(posedge clk) begin
        if (we) core[waddr] <= wdata;
    end

    assign rdata = core[raddr];

endmodule

// File: rtl/top_level.sv
// Decryption engine: recovers LFSR seed/taps from the padded block at DM[64..127],
// strips leading spaces and writes 54 result bytes to DM[0..53]. Optional macro: PARITY_CHECK_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for Start to fall after having been high
// ST_SEED   | latch seed from DM[64]
// ST_SEARCH | try each candidate tap pattern against DM[65..73]
// ST_SCAN   | rewind to seed, skip leading plaintext spaces to find k
// ST_WRITE  | write 54 decrypted bytes starting at plain[k] into DM[0..]
// ST_DONE   | Ack high until Start rises
module top_level
    import decrypt_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);

    state_t     state;
    logic       start_q;
    logic [6:0] seed;
    logic [6:0] lfsr;
    logic [6:0] taps;
    logic [3:0] cand;
    logic [3:0] step;
    logic [6:0] idx;
    logic [5:0] wr_addr;

    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [6:0] plain;
    logic       par_err;
    logic [6:0] lfsr_srch;
    logic [6:0] lfsr_run;

    data_mem DM (
        .clk   (Clk),
        .we    (mem_we),
        .waddr ({2'b00, wr_addr}),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        rd_addr = 8'(MSG_BASE);
        case (state)
            ST_SEARCH:         rd_addr = 8'(MSG_BASE) + 8'(step);
            ST_SCAN, ST_WRITE: rd_addr = 8'(MSG_BASE) + 8'(idx);
            default:           rd_addr = 8'(MSG_BASE);
        endcase
    end

`ifdef PARITY_CHECK_EN
    assign par_err = ^rd_data;
`else
    logic unused_bit7;
    assign unused_bit7 = rd_data[7];
    assign par_err     = 1'b0;
`endif

    assign plain     = rd_data[6:0] ^ lfsr;
    assign lfsr_srch = lfsr_next(lfsr, TAP_TABLE[cand]);
    assign lfsr_run  = lfsr_next(lfsr, taps);

    // Past the end of the 64-byte block the output is padded with spaces (0x00).
    assign mem_we    = (state == ST_WRITE);
    assign mem_wdata = idx[6] ? 8'h00 : {par_err, plain};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            seed    <= '0;
            lfsr    <= '0;
            taps    <= '0;
            cand    <= '0;
            step    <= '0;
            idx     <= '0;
            wr_addr <= '0;
            Ack     <= 1'b0;
        end else begin
            start_q <= Start;
            case (state)
                ST_IDLE: begin
                    if (!Start && start_q) state <= ST_SEED;
                end

                ST_SEED: begin
                    seed  <= rd_data[6:0];
                    lfsr  <= rd_data[6:0];
                    cand  <= '0;
                    step  <= 4'd1;
                    state <= ST_SEARCH;
                end

                ST_SEARCH: begin
                    if (rd_data[6:0] == lfsr_srch) begin
                        if (step == 4'(PRE_MIN - 1)) begin
                            taps  <= TAP_TABLE[cand];
                            lfsr  <= seed;
                            idx   <= '0;
                            state <= ST_SCAN;
                        end else begin
                            lfsr <= lfsr_srch;
                            step <= step + 4'd1;
                        end
                    end else begin
                        lfsr <= seed;
                        step <= 4'd1;
                        if (cand == 4'(NUM_TAPS - 1)) begin
                            // No candidate reproduced the pad: fall back to the first entry.
                            taps  <= TAP_TABLE[0];
                            idx   <= '0;
                            state <= ST_SCAN;
                        end else begin
                            cand <= cand + 4'd1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (idx == 7'd64 || plain != 7'd0 || par_err) begin
                        wr_addr <= '0;
                        state   <= ST_WRITE;
                    end else begin
                        idx  <= idx + 7'd1;
                        lfsr <= lfsr_run;
                    end
                end

                ST_WRITE: begin
                    idx  <= idx + 7'd1;
                    lfsr <= lfsr_run;
                    if (wr_addr == 6'(OUT_LEN - 1)) begin
                        Ack   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wr_addr <= wr_addr + 6'd1;
                    end
                end

                ST_DONE: begin
                    if (Start && !start_q) begin
                        Ack   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table of encrypted messages, scoreboard of expected DM bytes.
module tb_top_level;
    import decrypt_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    logic Start;
    logic Ack;

    always #5 Clk = ~Clk;

    top_level dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Ack   (Ack)
    );

    typedef struct packed {
        logic [6:0] taps;
        logic [6:0] seed;
        logic [5:0] pre;
        logic [7:0] exp0;
    } vec_t;

    vec_t  vecs [4];
    string msgs [4];

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [6:0] plain_m  [64];
    logic       err_m    [64];
    logic [7:0] cipher_m [64];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] t);
        logic fb;
        fb = 1'b0;
        for (int b = 0; b < 7; b++) fb = fb ^ (s[b] & t[b]);
        return {s[5:0], fb};
    endfunction

    task automatic build(input string msg, input logic [6:0] t, input logic [6:0] sd, input int pre);
        logic [6:0] s;
        logic [7:0] c;
        logic [6:0] low;
        s = sd;
        for (int i = 0; i < 64; i++) begin
            if (i >= pre && (i - pre) < msg.len()) c = msg[i - pre];
            else c = 8'h20;
            plain_m[i] = 7'(c - 8'h20);
            err_m[i]   = 1'b0;
            low        = plain_m[i] ^ s;
            cipher_m[i] = {^low, low};
            s = step7(s, t);
        end
    endtask

    task automatic preload();
        @(negedge Clk);
        for (int i = 0; i < 64; i++) dut.DM.core[MSG_BASE + i] <= cipher_m[i];
        for (int n = 0; n < OUT_LEN; n++) dut.DM.core[n] <= 8'hAA;
        @(negedge Clk);
    endtask

    task automatic push_expected();
        int k;
        int j;
        k = 64;
        for (int i = 63; i >= 0; i--) if (plain_m[i] != 7'd0 || err_m[i]) k = i;
        for (int n = 0; n < OUT_LEN; n++) begin
            j = k + n;
            if (j < 64) exp_q.push_back({err_m[j], plain_m[j]});
            else exp_q.push_back(8'h00);
        end
    endtask

    task automatic wait_ack(input string name);
        int cycles;
        cycles = 0;
        while (!Ack && cycles < 220) begin
            @(negedge Clk);
            cycles++;
        end
        check({name, " ack_within_220"}, int'(Ack), 1);
    endtask

    task automatic compare_out(input string name);
        logic [7:0] e;
        for (int n = 0; n < OUT_LEN; n++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s queue_empty_at_%0d", name, n), 1, 0);
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("%s dm[%0d]", name, n), int'(dut.DM.core[n]), int'(e));
        end
    endtask

    // Start is left high afterwards so the engine holds idle until the next launch.
    task automatic launch_and_check(input int v, input string name);
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        push_expected();
        wait_ack(name);
        compare_out(name);
        check({name, " dm0"}, int'(dut.DM.core[0]), int'(vecs[v].exp0));
        check({name, " taps"}, int'(dut.taps), int'(vecs[v].taps));
        repeat (4) @(negedge Clk);
        check({name, " ack_held"}, int'(Ack), 1);
        Start = 1'b1;
        @(negedge Clk);
        check({name, " ack_clear_on_rise"}, int'(Ack), 0);
        check({name, " back_to_idle"}, int'(dut.state), int'(ST_IDLE));
    endtask

    initial begin
        int changed;

        msgs[0] = "Mr. Watson, come here. I want to see you.";
        vecs[0] = '{taps: 7'h60, seed: 7'h01, pre: 6'd10, exp0: 8'h2D};
        msgs[1] = " Knowledge comes, but wisdom lingers.";
        vecs[1] = '{taps: 7'h7B, seed: 7'h55, pre: 6'd15, exp0: 8'h2B};
        msgs[2] = "";
        vecs[2] = '{taps: 7'h48, seed: 7'h33, pre: 6'd10, exp0: 8'h00};
        msgs[3] = "Parity guards every byte of this line.";
        vecs[3] = '{taps: 7'h69, seed: 7'h2A, pre: 6'd12, exp0: 8'h30};

        Reset = 1'b0;
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset ack", int'(Ack), 0);
        check("reset state", int'(dut.state), int'(ST_IDLE));
        check("reset taps", int'(dut.taps), 0);
        check("reset lfsr", int'(dut.lfsr), 0);
        Reset = 1'b1;

        // Start held high: nothing may run.
        build(msgs[0], vecs[0].taps, vecs[0].seed, int'(vecs[0].pre));
        preload();
        Start = 1'b1;
        repeat (10) @(negedge Clk);
        changed = 0;
        for (int n = 0; n < OUT_LEN; n++) if (dut.DM.core[n] != 8'hAA) changed++;
        check("hold no_writes", changed, 0);
        check("hold ack", int'(Ack), 0);
        check("hold state", int'(dut.state), int'(ST_IDLE));
        Start = 1'b0;
        push_expected();
        wait_ack("watson");
        check("watson dm1", int'(dut.DM.core[1]), 8'h52);
        check("watson dm2", int'(dut.DM.core[2]), 8'h0E);
        compare_out("watson");
        repeat (4) @(negedge Clk);
        check("watson ack_held", int'(Ack), 1);
        Start = 1'b1;
        @(negedge Clk);
        check("watson ack_clear_on_rise", int'(Ack), 0);

        for (int v = 1; v < 3; v++) begin
            build(msgs[v], vecs[v].taps, vecs[v].seed, int'(vecs[v].pre));
            preload();
            launch_and_check(v, $sformatf("vec%0d", v));
        end

        // Corrupted byte 30: under parity checking it becomes an error byte.
        build(msgs[3], vecs[3].taps, vecs[3].seed, int'(vecs[3].pre));
`ifdef PARITY_CHECK_EN
        cipher_m[30] = cipher_m[30] ^ 8'h08;
        plain_m[30]  = plain_m[30] ^ 7'h08;
        err_m[30]    = 1'b1;
`else
        cipher_m[30] = cipher_m[30] ^ 8'h80;
`endif
        preload();
        launch_and_check(3, "parity");

        // Reset in the middle of the tap search, then a clean rerun.
        build(msgs[1], vecs[1].taps, vecs[1].seed, int'(vecs[1].pre));
        preload();
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        check("midrun in_search", int'(dut.state), int'(ST_SEARCH));
        Reset = 1'b0;
        #1;
        check("midrun reset ack", int'(Ack), 0);
        check("midrun reset state", int'(dut.state), int'(ST_IDLE));
        check("midrun reset lfsr", int'(dut.lfsr), 0);
        Start = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        for (int n = 0; n < OUT_LEN; n++) dut.DM.core[n] <= 8'hAA;
        @(negedge Clk);
        launch_and_check(1, "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Hardwired message-decryption engine with its own data memory.
- Recovers the LFSR tap pattern and seed from a space-padded encrypted block at DM[64..127].
- Decrypts the block, strips all leading spaces, and writes 54 result bytes to DM[0..53], then raises Ack.
- Top of the decrypt datapath. The bench preloads memory and reads results hierarchically through instance DM, array core.

Parameters:
- MSG_BASE, 64, DM address of encrypted byte 0 (64 bytes)
- OUT_LEN, 54, number of result bytes written at DM[0..]
- PRE_MIN, 10, guaranteed minimum count of leading pad spaces

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request. Held high = hold idle; run launches on the first cycle it is sampled low after being high.
- Ack  output  1  done flag. High from run completion until the next Start rise or reset.

Behaviour:
- DM: 256x8 instance DM, array core. Combinational read, synchronous write, one access each per cycle. Reset does not clear it.
- Reset low: FSM=IDLE, Ack=0, all counters, LFSR and tap registers =0.
- LFSR step: next = {s[5:0], ^(s & taps)}, 7-bit.
- Candidate taps, in order: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- Encryption model: cipher[i][6:0] = (ascii[i]-0x20) ^ lfsr[i]. Pad bytes are 0x20, so cipher[i][6:0] = lfsr[i] for i < PRE_MIN.
- FSM states and actions:
  - IDLE: wait for the launch condition.
  - SEED: seed = DM[64][6:0].
  - SEARCH: per candidate t, step the LFSR from seed and compare against DM[65..73][6:0]. The first full match (9 bytes) fixes taps. On no match, taps=0x60.
  - SCAN: rewind to seed. While plain = DM[64+i][6:0]^lfsr == 0 and i<64, advance i and the LFSR. Result k = first non-space index.
  - WRITE: for n=0..53, DM[n] = {err, plain[k+n]}. When k+n > 63, write 0x00 (space).
  - DONE: Ack=1. Go to IDLE when Start rises.
- Result byte format: bit7 = error flag, bits[6:0] = plain value (ASCII minus 0x20).
- All-space message: k=64, so DM[0..53] are all 0x00.
- Latency: at most 9*10 + 64 + 54 + 8 cycles from launch to Ack.
- Start rising mid-run: ignored. Reset mid-run: aborts immediately to IDLE; partial DM writes remain.
- Arithmetic: all plain and LFSR values are 7-bit; no carries.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - Each cipher byte is checked for even parity over all 8 bits.
  - A failing byte outputs err=1, and its bits[6:0] still carry the XOR result.
  - In SCAN, a failing byte counts as non-space and terminates the scan.
  - SEARCH compares bits[6:0] only.
- Undefined: bit7 of every cipher byte is ignored and err is always 0.

Decomposition:
- Package decrypt_pkg:
  - tap table constant (9 x 7-bit)
  - MSG_BASE, OUT_LEN, PRE_MIN
  - FSM state enum
  - lfsr_next function
- Sub-module data_mem (instantiated as DM, array core): 256x8, async read, sync write.
- FSM and datapath stay in top_level.

Test Plan:
- Default case: "Mr. Watson, come here. I want to see you.", taps 0x60, seed 0x01, pre 10. Expect DM[0]=0x2D, DM[1]=0x52, DM[2]=0x0E, trailing bytes 0x00, Ack high within 220 cycles.
- Taps 0x7B, seed 0x55, pre 15, message " Knowledge comes, but wisdom lingers." Expect the leading message space stripped and DM[0]=0x2B ('K').
- All-space message with taps 0x48. Expect DM[0..53] all 0x00 and Ack asserted.
- PARITY_CHECK_EN defined, correct parity on all bytes, bit 3 flipped in cipher byte 30. Expect DM[30-k][7]=1 and all other bytes with bit7=0 and correct values.
- Start held high for 10 cycles. Expect no DM writes and Ack=0. Then Start low: run completes and Ack stays 1 until Start rises.
- Reset pulsed low mid-SEARCH. Expect Ack=0 and state IDLE at once. A fresh Start high-then-low gives correct output.
